// File: rtl/dsp_hazard_ctrl_pkg.sv
// Shared definitions for the DSP hazard/control unit: scoreboard entry layout,
// forwarding-select encodings and branch-handling modes.
package dsp_hazard_ctrl_pkg;

    localparam int unsigned FWD_SEL_REGFILE = 0;
    localparam int unsigned FWD_SEL_EX      = 1;
    localparam int unsigned FWD_SEL_MEM     = 2;
    localparam int unsigned FWD_SEL_WB      = 3;

    // Entry layout, LSB first: is_branch, is_load, dest[W-1:0], we, valid
    localparam int unsigned SB_BRANCH_BIT = 0;
    localparam int unsigned SB_LOAD_BIT   = 1;
    localparam int unsigned SB_DEST_LSB   = 2;

    function automatic int unsigned sb_we_bit(input int unsigned addr_w);
        return SB_DEST_LSB + addr_w;
    endfunction

    function automatic int unsigned sb_valid_bit(input int unsigned addr_w);
        return SB_DEST_LSB + addr_w + 1;
    endfunction

    function automatic int unsigned sb_width(input int unsigned addr_w);
        return SB_DEST_LSB + addr_w + 2;
    endfunction

    typedef enum logic [0:0] {
        BR_STALL      = 1'b0,
        BR_PREDICT_NT = 1'b1
    } br_mode_e;

endpackage

// File: rtl/dsp_hazard_src_cmp.sv
// Per-source compare against the scoreboard: finds the youngest in-flight writer
// of the source register and reports whether its result is forwardable yet.
module dsp_hazard_src_cmp
    import dsp_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN     = 5,
    parameter int unsigned PIPE_DEPTH       = 3,
    parameter int unsigned ALU_READY_STAGE  = 1,
    parameter int unsigned LOAD_READY_STAGE = 2,
    parameter int unsigned FWD_SEL_W        = 2
) (
    input  logic [REG_ADDR_LEN-1:0]            src_addr,
    input  logic                               src_used,
    input  logic [PIPE_DEPTH-1:0]              sb_wr,
    input  logic [PIPE_DEPTH*REG_ADDR_LEN-1:0] sb_dest,
    input  logic [PIPE_DEPTH-1:0]              sb_load,
    output logic                               hit,
    output logic                               ready,
    output logic [FWD_SEL_W-1:0]               k
);

    // Walk oldest to youngest so the last match (lowest stage) wins.
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        k     = '0;
        for (int unsigned s = PIPE_DEPTH; s >= 1; s--) begin
            if (src_used && sb_wr[s-1] &&
                sb_dest[(s-1)*REG_ADDR_LEN +: REG_ADDR_LEN] == src_addr) begin
                hit   = 1'b1;
                ready = (s >= (sb_load[s-1] ? LOAD_READY_STAGE : ALU_READY_STAGE));
                k     = FWD_SEL_W'(s);
            end
        end
    end

endmodule

// File: rtl/dsp_hazard_ctrl.sv
// Pipeline hazard/control unit: scoreboard of in-flight writers behind decode,
// forwarding selects, load-use interlock, branch stall/flush and stall counter.
module dsp_hazard_ctrl
    import dsp_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN     = 5,
    parameter int unsigned NUM_SRC          = 3,
    parameter int unsigned PIPE_DEPTH       = 3,
    parameter int unsigned ALU_READY_STAGE  = 1,
    parameter int unsigned LOAD_READY_STAGE = 2,
    parameter int unsigned BR_RES_STAGE     = 2,
    parameter int unsigned BR_MODE          = 0,
    parameter int unsigned FWD_SEL_W        = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            id_valid,
    input  logic [NUM_SRC*REG_ADDR_LEN-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]              id_src_used,
    input  logic [REG_ADDR_LEN-1:0]         id_dest,
    input  logic                            id_we,
    input  logic                            id_is_load,
    input  logic                            id_is_branch,
    input  logic                            br_resolve,
    input  logic                            br_taken,
    output logic                            stall_fetch,
    output logic                            bubble,
    output logic                            flush,
    output logic [NUM_SRC*FWD_SEL_W-1:0]    fwd_sel,
    output logic [1:0]                      br_pending,
    output logic [15:0]                     hazard_cnt
);

    localparam int unsigned SB_W     = sb_width(REG_ADDR_LEN);
    localparam int unsigned SB_VALID = sb_valid_bit(REG_ADDR_LEN);
    localparam int unsigned SB_WE    = sb_we_bit(REG_ADDR_LEN);
    localparam br_mode_e    MODE     = (BR_MODE == 0) ? BR_STALL : BR_PREDICT_NT;

    logic [PIPE_DEPTH*SB_W-1:0]         sb_q, sb_d;
    logic [PIPE_DEPTH-1:0]              sb_wr, sb_load, sb_br_unused;
    logic [PIPE_DEPTH*REG_ADDR_LEN-1:0] sb_dest;
    logic [NUM_SRC-1:0]                 src_hit, src_ready;
    logic [NUM_SRC*FWD_SEL_W-1:0]       src_k, fwd_int;
    logic [1:0]                         br_cnt;
    logic load_use, flush_int, bubble_int, issue, br_issue, br_dec, stall_int;

    always_comb begin
        sb_wr        = '0;
        sb_load      = '0;
        sb_dest      = '0;
        sb_br_unused = '0;
        for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
            sb_wr[s]   = sb_q[s*SB_W + SB_VALID] & sb_q[s*SB_W + SB_WE];
            sb_load[s] = sb_q[s*SB_W + SB_LOAD_BIT];
            sb_dest[s*REG_ADDR_LEN +: REG_ADDR_LEN] = sb_q[s*SB_W + SB_DEST_LSB +: REG_ADDR_LEN];
            // Branch flags ride along for observability; nothing consumes them.
            sb_br_unused[s] = sb_q[s*SB_W + SB_BRANCH_BIT];
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        dsp_hazard_src_cmp #(
            .REG_ADDR_LEN    (REG_ADDR_LEN),
            .PIPE_DEPTH      (PIPE_DEPTH),
            .ALU_READY_STAGE (ALU_READY_STAGE),
            .LOAD_READY_STAGE(LOAD_READY_STAGE),
            .FWD_SEL_W       (FWD_SEL_W)
        ) u_cmp (
            .src_addr(id_src_addr[i*REG_ADDR_LEN +: REG_ADDR_LEN]),
            .src_used(id_src_used[i]),
            .sb_wr   (sb_wr),
            .sb_dest (sb_dest),
            .sb_load (sb_load),
            .hit     (src_hit[i]),
            .ready   (src_ready[i]),
            .k       (src_k[i*FWD_SEL_W +: FWD_SEL_W])
        );
    end

    always_comb begin
        load_use   = id_valid & |(src_hit & ~src_ready);
        flush_int  = (MODE == BR_PREDICT_NT) & br_resolve & br_taken;
        bubble_int = load_use & ~flush_int;
        issue      = id_valid & ~bubble_int & ~flush_int;
        br_issue   = issue & id_is_branch;
        br_dec     = br_resolve & (br_cnt != '0);
        if (MODE == BR_STALL) begin
            stall_int = bubble_int | (br_cnt != '0) | br_issue;
        end else begin
            stall_int = bubble_int;
        end
        fwd_int = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            fwd_int[i*FWD_SEL_W +: FWD_SEL_W] = (src_hit[i] & src_ready[i]) ?
                src_k[i*FWD_SEL_W +: FWD_SEL_W] : FWD_SEL_W'(FWD_SEL_REGFILE);
        end
        // Outputs read as idle for the whole time reset is held, not just after the edge.
        stall_fetch = rst & stall_int;
        bubble      = rst & bubble_int;
        flush       = rst & flush_int;
        fwd_sel     = rst ? fwd_int : '0;
    end

    always_comb begin
        sb_d = '0;
        sb_d[0 +: SB_W] = issue ?
            {1'b1, id_we, id_dest, id_is_load, id_is_branch} : '0;
        for (int unsigned s = 1; s < PIPE_DEPTH; s++) begin
            sb_d[s*SB_W +: SB_W] = (flush_int && s < BR_RES_STAGE) ?
                '0 : sb_q[(s-1)*SB_W +: SB_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q       <= '0;
            br_cnt     <= '0;
            hazard_cnt <= '0;
        end else begin
            sb_q <= sb_d;
            if (bubble_int && hazard_cnt != '1) begin
                hazard_cnt <= hazard_cnt + 16'd1;
            end
            // A taken flush retires the resolving branch and squashes every younger one.
            if (flush_int) begin
                br_cnt <= '0;
            end else if (br_issue && !br_dec && br_cnt != '1) begin
                br_cnt <= br_cnt + 2'd1;
            end else if (br_dec && !br_issue) begin
                br_cnt <= br_cnt - 2'd1;
            end
        end
    end

    assign br_pending = br_cnt;

endmodule

// File: tb/tb_dsp_hazard_ctrl.sv
// Bench for dsp_hazard_ctrl: one instance per branch mode, checked against an
// in-bench model of recently issued instructions.
module tb_dsp_hazard_ctrl;

    localparam int unsigned W  = 5;
    localparam int unsigned NS = 3;
    localparam int unsigned D  = 3;
    localparam int unsigned FW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic          id_valid = 1'b0;
    logic [NS*W-1:0] id_src_addr = '0;
    logic [NS-1:0] id_src_used = '0;
    logic [W-1:0]  id_dest = '0;
    logic id_we = 1'b0, id_is_load = 1'b0, id_is_branch = 1'b0;
    logic br_resolve = 1'b0, br_taken = 1'b0;

    logic           sf[2], bub[2], fl[2];
    logic [NS*FW-1:0] fwd[2];
    logic [1:0]     bp[2];
    logic [15:0]    hc[2];

    always #5 clk = ~clk;

    dsp_hazard_ctrl #(.BR_MODE(0)) u_mode0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dest(id_dest), .id_we(id_we),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch),
        .br_resolve(br_resolve), .br_taken(br_taken),
        .stall_fetch(sf[0]), .bubble(bub[0]), .flush(fl[0]), .fwd_sel(fwd[0]),
        .br_pending(bp[0]), .hazard_cnt(hc[0])
    );

    dsp_hazard_ctrl #(.BR_MODE(1)) u_mode1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dest(id_dest), .id_we(id_we),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch),
        .br_resolve(br_resolve), .br_taken(br_taken),
        .stall_fetch(sf[1]), .bubble(bub[1]), .flush(fl[1]), .fwd_sel(fwd[1]),
        .br_pending(bp[1]), .hazard_cnt(hc[1])
    );

    typedef struct {
        bit          v;
        bit          we;
        int unsigned dest;
        bit          ld;
        bit          br;
    } ent_t;

    // hist[m][k]: the instruction issued k cycles ago (k=1 youngest)
    ent_t hist[2][1:D];
    int   pend[2];
    int   hcnt[2];
    bit   e_sf[2], e_bub[2], e_fl[2], e_iss[2];
    int   e_fwd[2][NS];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void clear_model();
        ent_t z;
        z = '{default: 0};
        for (int m = 0; m < 2; m++) begin
            for (int k = 1; k <= D; k++) hist[m][k] = z;
            pend[m] = 0;
            hcnt[m] = 0;
        end
    endfunction

    function automatic void eval_model();
        for (int m = 0; m < 2; m++) begin
            bit ls;
            ls = 1'b0;
            for (int i = 0; i < NS; i++) begin
                bit found;
                found = 1'b0;
                e_fwd[m][i] = 0;
                if (id_src_used[i]) begin
                    for (int k = 1; k <= D; k++) begin
                        if (!found && hist[m][k].v && hist[m][k].we &&
                            hist[m][k].dest == int'(id_src_addr[i*W +: W])) begin
                            found = 1'b1;
                            if (k >= (hist[m][k].ld ? 2 : 1)) e_fwd[m][i] = k;
                            else ls = 1'b1;
                        end
                    end
                end
            end
            ls        = ls && id_valid;
            e_fl[m]   = (m == 1) && br_resolve && br_taken;
            e_bub[m]  = ls && !e_fl[m];
            e_iss[m]  = id_valid && !e_bub[m] && !e_fl[m];
            e_sf[m]   = (m == 0) ? (e_bub[m] || pend[m] != 0 || (e_iss[m] && id_is_branch))
                                 : e_bub[m];
        end
    endfunction

    function automatic void update_model();
        ent_t z;
        z = '{default: 0};
        for (int m = 0; m < 2; m++) begin
            int p;
            if (e_bub[m] && hcnt[m] < 65535) hcnt[m]++;
            if (e_fl[m]) begin
                pend[m] = 0;
            end else begin
                p = pend[m];
                if (e_iss[m] && id_is_branch) p++;
                if (br_resolve && pend[m] > 0) p--;
                pend[m] = (p > 3) ? 3 : p;
            end
            for (int k = D; k >= 2; k--) hist[m][k] = (e_fl[m] && k - 1 < 2) ? z : hist[m][k-1];
            if (e_iss[m]) hist[m][1] = '{1'b1, id_we, int'(id_dest), id_is_load, id_is_branch};
            else          hist[m][1] = z;
        end
    endfunction

    task automatic compare();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d_stall_fetch", m), sf[m], e_sf[m]);
            chk($sformatf("m%0d_bubble", m), bub[m], e_bub[m]);
            chk($sformatf("m%0d_flush", m), fl[m], e_fl[m]);
            chk($sformatf("m%0d_br_pending", m), bp[m], pend[m]);
            chk($sformatf("m%0d_hazard_cnt", m), hc[m], hcnt[m]);
            if (!e_bub[m]) begin
                for (int i = 0; i < NS; i++)
                    chk($sformatf("m%0d_fwd_sel%0d", m, i), fwd[m][i*FW +: FW], e_fwd[m][i]);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s_m%0d_sf", tag, m), sf[m], 0);
            chk($sformatf("%s_m%0d_bubble", tag, m), bub[m], 0);
            chk($sformatf("%s_m%0d_flush", tag, m), fl[m], 0);
            chk($sformatf("%s_m%0d_fwd", tag, m), fwd[m], 0);
            chk($sformatf("%s_m%0d_bp", tag, m), bp[m], 0);
            chk($sformatf("%s_m%0d_hc", tag, m), hc[m], 0);
        end
    endtask

    task automatic set_in(input bit v, input int unsigned s0, input int unsigned s1,
                          input int unsigned s2, input bit [2:0] used, input int unsigned dst,
                          input bit we, input bit ld, input bit br, input bit res, input bit tk);
        id_valid     = v;
        id_src_addr  = {W'(s2), W'(s1), W'(s0)};
        id_src_used  = used;
        id_dest      = W'(dst);
        id_we        = we;
        id_is_load   = ld;
        id_is_branch = br;
        br_resolve   = res;
        br_taken     = tk;
    endtask

    task automatic look();
        #1;
        eval_model();
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic nop();
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        look();
        tick();
    endtask

    initial begin
        clear_model();
        #2;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) nop();

        // ALU writer r3, then readers one and two cycles later
        set_in(1, 0, 0, 0, 3'b000, 3, 1, 0, 0, 0, 0); look(); tick();
        set_in(1, 3, 0, 0, 3'b001, 6, 1, 0, 0, 0, 0); look();
        chk("t1_fwd_ex", fwd[0][1:0], 1);
        chk("t1_no_stall", sf[0], 0);
        tick();
        set_in(1, 3, 0, 0, 3'b001, 7, 1, 0, 0, 0, 0); look();
        chk("t1_fwd_mem", fwd[0][1:0], 2);
        tick();
        repeat (3) nop();

        // Load-use interlock on source 1
        set_in(1, 0, 0, 0, 3'b000, 5, 1, 1, 0, 0, 0); look(); tick();
        set_in(1, 0, 5, 0, 3'b010, 8, 1, 0, 0, 0, 0); look();
        chk("t2_stall", sf[0], 1);
        chk("t2_bubble", bub[0], 1);
        tick();
        chk("t2_hcnt", hc[0], 1);
        look();
        chk("t2_fwd_mem", fwd[0][3:2], 2);
        chk("t2_released", bub[0], 0);
        tick();
        repeat (3) nop();

        // r4 written at stage 3 and stage 1: youngest wins
        set_in(1, 0, 0, 0, 3'b000, 4, 1, 0, 0, 0, 0); look(); tick();
        set_in(1, 0, 0, 0, 3'b000, 7, 1, 0, 0, 0, 0); look(); tick();
        set_in(1, 0, 0, 0, 3'b000, 4, 1, 0, 0, 0, 0); look(); tick();
        set_in(1, 0, 0, 4, 3'b100, 9, 1, 0, 0, 0, 0); look();
        chk("t3_youngest", fwd[0][5:4], 1);
        tick();
        repeat (3) nop();

        // Branch stall in mode 0
        set_in(1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0); look();
        chk("t4_br_issue_stall", sf[0], 1);
        chk("t4_no_bubble", bub[0], 0);
        tick();
        chk("t4_pending", bp[0], 1);
        set_in(1, 1, 0, 0, 3'b001, 10, 1, 0, 0, 0, 0); look();
        chk("t4_hold", sf[0], 1);
        tick();
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0); look(); tick();
        chk("t4_resolved", bp[0], 0);
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0); look();
        chk("t4_fetch_free", sf[0], 0);
        tick();
        repeat (3) nop();

        // Taken flush overrides a load-use stall in mode 1
        set_in(1, 0, 0, 0, 3'b000, 5, 1, 1, 0, 0, 0); look(); tick();
        set_in(1, 0, 5, 0, 3'b010, 8, 1, 0, 0, 1, 1); look();
        chk("t5_flush", fl[1], 1);
        chk("t5_no_bubble", bub[1], 0);
        chk("t5_no_stall", sf[1], 0);
        chk("t5_m0_bubble", bub[0], 1);
        chk("t5_m0_no_flush", fl[0], 0);
        tick();
        set_in(1, 0, 5, 0, 3'b010, 11, 1, 0, 0, 0, 0); look();
        chk("t5_squashed", fwd[1][3:2], 0);
        chk("t5_m0_fwd", fwd[0][3:2], 2);
        tick();
        repeat (3) nop();

        // Reset asserted mid-stall with a branch pending
        set_in(1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0); look(); tick();
        set_in(1, 0, 0, 0, 3'b000, 5, 1, 1, 0, 0, 0); look(); tick();
        set_in(1, 5, 0, 0, 3'b001, 12, 1, 0, 0, 0, 0); look();
        chk("t6_stall", bub[0], 1);
        chk("t6_pending", bp[0], 1);
        #1;
        rst = 1'b0;
        #1;
        check_idle("t6_rst");
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b1;
        look();
        chk("t6_no_match", fwd[0][1:0], 0);
        chk("t6_no_stall", sf[0], 0);
        tick();
        repeat (3) nop();

        // Random traffic on a small register window
        repeat (400) begin
            set_in($urandom % 4 != 0, $urandom % 6, $urandom % 6, $urandom % 6,
                   3'($urandom), $urandom % 6, 1'($urandom), $urandom % 4 == 0,
                   $urandom % 8 == 0, $urandom % 5 == 0, 1'($urandom));
            look();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
